// File: rtl/validador_pecas.sv
// validador_pecas: conflict validator and board store behind the piece-placement FSM.
// A candidate piece is captured, its cells are walked one per clock and checked
// for bounds and overlap on the selected player's 8x8 board. A later commit writes
// the validated piece into that board. A registered read port exposes board cells.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   valida, armazena           check / commit requests (rising edge sampled)
//   jogador, tipo, X1, Y1,     candidate piece (board, type, anchor, direction)
//   direcao
//   rd_jogador, rd_x, rd_y     read-port board and coordinate
//   conflito, pronto           check result and its one-cycle strobe
//   gravado                    one-cycle strobe when a commit finishes
//   qtd_pecas0, qtd_pecas1     pieces stored per board
//   cheio                      both boards hold MAX_PECAS pieces
//   rd_ocupado                 registered occupancy at the read coordinate
//
// Build option: define VALIDADOR_ADJACENCIA_EN to also reject cells whose in-range
// 8-neighbours are occupied (ships may not touch). Latency is the same either way.
module validador_pecas #(
    parameter int TAM_TAB   = 8,
    parameter int MAX_PECAS = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valida,
    input  logic       armazena,
    input  logic       jogador,
    input  logic [2:0] tipo,
    input  logic [3:0] X1,
    input  logic [3:0] Y1,
    input  logic       direcao,
    input  logic       rd_jogador,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic       conflito,
    output logic       pronto,
    output logic       gravado,
    output logic [3:0] qtd_pecas0,
    output logic [3:0] qtd_pecas1,
    output logic       cheio,
    output logic       rd_ocupado
);

    localparam int         NC   = TAM_TAB * TAM_TAB;
    localparam int         IW   = $clog2(NC);
    localparam logic [3:0] MAX4 = 4'(MAX_PECAS);

    localparam logic [2:0] OCIOSO    = 3'd0;
    localparam logic [2:0] CHECA     = 3'd1;
    localparam logic [2:0] RESULTADO = 3'd2;
    localparam logic [2:0] AGUARDA   = 3'd3;
    localparam logic [2:0] GRAVA     = 3'd4;

    logic [2:0]         estado_q;
    logic               valida_ant_q, armazena_ant_q;
    logic               jog_q, dir_q;
    logic [2:0]         tipo_q;
    logic [3:0]         x_q, y_q;
    logic [2:0]         k_q;
    logic               flag_q;
    logic [1:0][NC-1:0] tab_q;

    logic               valida_sub, armazena_sub;
    logic [4:0]         dx, dy, cx, cy;
    logic [2:0]         len;
    logic               tipo_ok, ultimo, conf_celula, tab_cheio;
    logic [NC-1:0]      tab_sel;
    logic [IW-1:0]      wr_idx;

    function automatic logic em_faixa(input int x, input int y);
        return (x >= 1) && (x <= TAM_TAB) && (y >= 1) && (y <= TAM_TAB);
    endfunction

    // Out-of-range coordinates read as empty.
    function automatic logic ocupado(input logic [NC-1:0] tab, input int x, input int y);
        if (!em_faixa(x, y)) return 1'b0;
        return tab[IW'((y - 1) * TAM_TAB + (x - 1))];
    endfunction

    assign valida_sub   = valida & ~valida_ant_q;
    assign armazena_sub = armazena & ~armazena_ant_q;
    assign cheio        = (qtd_pecas0 == MAX4) && (qtd_pecas1 == MAX4);
    assign tab_sel      = tab_q[jog_q];
    assign tab_cheio    = (jog_q ? qtd_pecas1 : qtd_pecas0) == MAX4;
    assign tipo_ok      = (tipo_q <= 3'd4);

    always_comb begin
        unique case (tipo_q)
            3'd0:    len = 3'd1;
            3'd1:    len = 3'd2;
            3'd2:    len = 3'd3;
            3'd3:    len = 3'd4;
            3'd4:    len = 3'd5;
            default: len = 3'd1;
        endcase
    end

    assign ultimo = (k_q == len - 3'd1);

    // Offset of cell k from the anchor; sums are 5-bit so nothing wraps back in range.
    always_comb begin
        dx = 5'd0;
        dy = 5'd0;
        if (tipo_q == 3'd2) begin
            case (k_q)
                3'd1: begin
                    dx = 5'd1;
                    dy = 5'd1;
                end
                3'd2: begin
                    if (dir_q) dy = 5'd2;
                    else       dx = 5'd2;
                end
                default: ;
            endcase
        end else if (dir_q) begin
            dy = {2'b00, k_q};
        end else begin
            dx = {2'b00, k_q};
        end
        cx = {1'b0, x_q} + dx;
        cy = {1'b0, y_q} + dy;
    end

    always_comb begin
        conf_celula = !em_faixa(int'(cx), int'(cy)) || ocupado(tab_sel, int'(cx), int'(cy));
`ifdef VALIDADOR_ADJACENCIA_EN
        for (int ddy = -1; ddy <= 1; ddy++) begin
            for (int ddx = -1; ddx <= 1; ddx++) begin
                if (ocupado(tab_sel, int'(cx) + ddx, int'(cy) + ddy)) conf_celula = 1'b1;
            end
        end
`endif
    end

    assign wr_idx = IW'((int'(cy) - 1) * TAM_TAB + (int'(cx) - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            valida_ant_q   <= 1'b0;
            armazena_ant_q <= 1'b0;
            jog_q          <= 1'b0;
            dir_q          <= 1'b0;
            tipo_q         <= 3'd0;
            x_q            <= 4'd0;
            y_q            <= 4'd0;
            k_q            <= 3'd0;
            flag_q         <= 1'b0;
            tab_q          <= '0;
            conflito       <= 1'b0;
            pronto         <= 1'b0;
            gravado        <= 1'b0;
            qtd_pecas0     <= 4'd0;
            qtd_pecas1     <= 4'd0;
            rd_ocupado     <= 1'b0;
        end else begin
            valida_ant_q   <= valida;
            armazena_ant_q <= armazena;
            pronto         <= 1'b0;
            gravado        <= 1'b0;
            rd_ocupado     <= ocupado(tab_q[rd_jogador], int'(rd_x), int'(rd_y));

            case (estado_q)
                OCIOSO: begin
                    if (valida_sub) begin
                        jog_q    <= jogador;
                        tipo_q   <= tipo;
                        x_q      <= X1;
                        y_q      <= Y1;
                        dir_q    <= direcao;
                        k_q      <= 3'd0;
                        flag_q   <= 1'b0;
                        estado_q <= CHECA;
                    end
                end
                CHECA: begin
                    if (!tipo_ok) begin
                        flag_q   <= 1'b1;
                        estado_q <= RESULTADO;
                    end else begin
                        // A full board rejects every candidate; latency stays fixed.
                        flag_q <= flag_q | conf_celula | tab_cheio;
                        if (ultimo) estado_q <= RESULTADO;
                        else        k_q      <= k_q + 3'd1;
                    end
                end
                RESULTADO: begin
                    conflito <= flag_q;
                    pronto   <= 1'b1;
                    estado_q <= flag_q ? OCIOSO : AGUARDA;
                end
                AGUARDA: begin
                    if (armazena_sub) begin
                        k_q      <= 3'd0;
                        estado_q <= GRAVA;
                    end else if (valida_sub) begin
                        jog_q    <= jogador;
                        tipo_q   <= tipo;
                        x_q      <= X1;
                        y_q      <= Y1;
                        dir_q    <= direcao;
                        k_q      <= 3'd0;
                        flag_q   <= 1'b0;
                        estado_q <= CHECA;
                    end
                end
                GRAVA: begin
                    if (em_faixa(int'(cx), int'(cy))) tab_q[jog_q][wr_idx] <= 1'b1;
                    if (ultimo) begin
                        if (jog_q) qtd_pecas1 <= qtd_pecas1 + 4'd1;
                        else       qtd_pecas0 <= qtd_pecas0 + 4'd1;
                        gravado  <= 1'b1;
                        conflito <= 1'b0;
                        estado_q <= OCIOSO;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_validador_pecas.sv
// tb_validador_pecas: directed bench for validador_pecas. Expected check results are
// queued when a check is launched and compared when pronto appears.
module tb_validador_pecas;

    logic       clk = 1'b0;
    logic       reset, valida, armazena, jogador, direcao, rd_jogador;
    logic [2:0] tipo;
    logic [3:0] X1, Y1, rd_x, rd_y;
    logic       conflito, pronto, gravado, cheio, rd_ocupado;
    logic [3:0] qtd_pecas0, qtd_pecas1;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_q[$];
    logic adj_exp;

    always #5 clk = ~clk;

    validador_pecas dut (
        .clk        (clk),
        .reset      (reset),
        .valida     (valida),
        .armazena   (armazena),
        .jogador    (jogador),
        .tipo       (tipo),
        .X1         (X1),
        .Y1         (Y1),
        .direcao    (direcao),
        .rd_jogador (rd_jogador),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .conflito   (conflito),
        .pronto     (pronto),
        .gravado    (gravado),
        .qtd_pecas0 (qtd_pecas0),
        .qtd_pecas1 (qtd_pecas1),
        .cheio      (cheio),
        .rd_ocupado (rd_ocupado)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int plen(input logic [2:0] t);
        case (t)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 3;
            3'd3:    return 4;
            3'd4:    return 5;
            default: return 1;
        endcase
    endfunction

    // Launch a check, scramble the inputs after capture, then wait for pronto.
    task automatic run_check(input string tag, input logic j, input logic [2:0] t,
                             input logic [3:0] x, input logic [3:0] y, input logic d,
                             input logic e);
        int   cnt;
        bit   seen;
        logic ex;
        jogador = j; tipo = t; X1 = x; Y1 = y; direcao = d; valida = 1'b1;
        exp_q.push_back(e);
        tick();
        valida = 1'b0; tipo = 3'd7; X1 = 4'd0; Y1 = 4'd15; jogador = ~j; direcao = ~d;
        cnt = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            cnt++;
            if (pronto) seen = 1;
        end
        check({tag, " pronto"}, 32'(seen), 32'd1);
        ex = exp_q.pop_front();
        if (seen) begin
            check({tag, " conflito"}, 32'(conflito), 32'(ex));
            check({tag, " latencia"}, 32'(cnt), 32'(plen(t) + 1));
        end
    endtask

    task automatic do_commit(input string tag, input int len, input logic j,
                             input logic [3:0] exp_qtd);
        int cnt;
        bit seen;
        armazena = 1'b1;
        tick();
        armazena = 1'b0;
        cnt = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            cnt++;
            if (gravado) seen = 1;
        end
        check({tag, " gravado"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " latencia"}, 32'(cnt), 32'(len));
            check({tag, " conflito"}, 32'(conflito), 32'd0);
            check({tag, " qtd"}, 32'(j ? qtd_pecas1 : qtd_pecas0), 32'(exp_qtd));
        end
    endtask

    task automatic rd_check(input string tag, input logic j, input logic [3:0] x,
                            input logic [3:0] y, input logic e);
        rd_jogador = j; rd_x = x; rd_y = y;
        tick();
        check(tag, 32'(rd_ocupado), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit seen;
        int extra;
`ifdef VALIDADOR_ADJACENCIA_EN
        adj_exp = 1'b1;
`else
        adj_exp = 1'b0;
`endif
        reset = 1'b1; valida = 1'b0; armazena = 1'b0; jogador = 1'b0; direcao = 1'b0;
        tipo = 3'd0; X1 = 4'd0; Y1 = 4'd0; rd_jogador = 1'b0; rd_x = 4'd3; rd_y = 4'd4;
        tick();
        tick();
        check("reset conflito", 32'(conflito), 32'd0);
        check("reset pronto", 32'(pronto), 32'd0);
        check("reset gravado", 32'(gravado), 32'd0);
        check("reset qtd0", 32'(qtd_pecas0), 32'd0);
        check("reset qtd1", 32'(qtd_pecas1), 32'd0);
        check("reset cheio", 32'(cheio), 32'd0);
        check("reset rd", 32'(rd_ocupado), 32'd0);
        reset = 1'b0;
        tick();

        // Cruzador commit and read-back.
        run_check("cruzador j0 (3,4)", 1'b0, 3'd1, 4'd3, 4'd4, 1'b0, 1'b0);
        do_commit("cruzador commit", 2, 1'b0, 4'd1);
        rd_check("rd j0 (3,4)", 1'b0, 4'd3, 4'd4, 1'b1);
        rd_check("rd j0 (4,4)", 1'b0, 4'd4, 4'd4, 1'b1);
        rd_check("rd j0 (5,4)", 1'b0, 4'd5, 4'd4, 1'b0);
        rd_check("rd j1 (3,4)", 1'b1, 4'd3, 4'd4, 1'b0);
        rd_check("rd j0 (0,4)", 1'b0, 4'd0, 4'd4, 1'b0);
        rd_check("rd j0 (9,4)", 1'b0, 4'd9, 4'd4, 1'b0);

        // Out of bounds, then an ignored commit.
        run_check("porta j1 (5,2)", 1'b1, 3'd4, 4'd5, 4'd2, 1'b0, 1'b1);
        armazena = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            armazena = 1'b0;
            if (gravado) seen = 1;
        end
        check("commit ignorado gravado", 32'(seen), 32'd0);
        check("commit ignorado qtd1", 32'(qtd_pecas1), 32'd0);
        check("conflito retido", 32'(conflito), 32'd1);

        // Overlap and board independence.
        run_check("sub j0 (4,4)", 1'b0, 3'd0, 4'd4, 4'd4, 1'b0, 1'b1);
        run_check("sub j1 (4,4)", 1'b1, 3'd0, 4'd4, 4'd4, 1'b0, 1'b0);

        // Hidroaviao: vertical off the bottom, then valid placement.
        run_check("hidro j0 (1,7)", 1'b0, 3'd2, 4'd1, 4'd7, 1'b1, 1'b1);
        run_check("hidro j0 (1,6)", 1'b0, 3'd2, 4'd1, 4'd6, 1'b1, 1'b0);
        do_commit("hidro commit", 3, 1'b0, 4'd2);
        rd_check("rd j0 (1,6)", 1'b0, 4'd1, 4'd6, 1'b1);
        rd_check("rd j0 (2,7)", 1'b0, 4'd2, 4'd7, 1'b1);
        rd_check("rd j0 (1,8)", 1'b0, 4'd1, 4'd8, 1'b1);
        rd_check("rd j0 (2,6)", 1'b0, 4'd2, 4'd6, 1'b0);

        run_check("adjacencia j0 (5,5)", 1'b0, 3'd0, 4'd5, 4'd5, 1'b0, adj_exp);
        run_check("tipo invalido", 1'b0, 3'd5, 4'd2, 4'd2, 1'b0, 1'b1);

        // Held valida gives a single check.
        jogador = 1'b1; tipo = 3'd0; X1 = 4'd8; Y1 = 4'd8; direcao = 1'b0; valida = 1'b1;
        exp_q.push_back(1'b0);
        tick();
        cnt = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            cnt++;
            if (pronto) seen = 1;
        end
        check("valida mantido pronto", 32'(seen), 32'd1);
        check("valida mantido conflito", 32'(conflito), 32'(exp_q.pop_front()));
        check("valida mantido latencia", 32'(cnt), 32'd2);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pronto) extra++;
        end
        check("valida mantido repeticao", 32'(extra), 32'd0);
        valida = 1'b0;
        tick();
        do_commit("sub j1 commit", 1, 1'b1, 4'd1);
        rd_check("rd j1 (8,8)", 1'b1, 4'd8, 4'd8, 1'b1);

        // Reset during the third write cycle of an encouracado.
        run_check("encouracado j0 (1,1)", 1'b0, 3'd3, 4'd1, 4'd1, 1'b0, 1'b0);
        rd_jogador = 1'b0; rd_x = 4'd1; rd_y = 4'd1;
        armazena = 1'b1;
        tick();
        armazena = 1'b0;
        tick();
        tick();
        check("escrita parcial visivel", 32'(rd_ocupado), 32'd1);
        reset = 1'b1;
        #1;
        check("reset rd imediato", 32'(rd_ocupado), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("pos-reset qtd0", 32'(qtd_pecas0), 32'd0);
        check("pos-reset qtd1", 32'(qtd_pecas1), 32'd0);
        check("pos-reset gravado", 32'(gravado), 32'd0);
        rd_check("pos-reset j0 (1,1)", 1'b0, 4'd1, 4'd1, 1'b0);
        rd_check("pos-reset j0 (2,1)", 1'b0, 4'd2, 4'd1, 1'b0);
        rd_check("pos-reset j0 (3,4)", 1'b0, 4'd3, 4'd4, 1'b0);
        rd_check("pos-reset j0 (1,6)", 1'b0, 4'd1, 4'd6, 1'b0);
        rd_check("pos-reset j1 (8,8)", 1'b1, 4'd8, 4'd8, 1'b0);
        run_check("pos-reset cruzador", 1'b0, 3'd1, 4'd3, 4'd4, 1'b0, 1'b0);
        do_commit("pos-reset commit", 2, 1'b0, 4'd1);

        // Fill both boards and confirm a full board rejects further pieces.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int j = 0; j < 2; j++) begin
            for (int n = 0; n < 11; n++) begin
                run_check($sformatf("enche j%0d n%0d", j, n), 1'(j), 3'd0,
                          4'(1 + 2 * (n % 4)), 4'(1 + 2 * (n / 4)), 1'b0, 1'b0);
                do_commit($sformatf("enche commit j%0d n%0d", j, n), 1, 1'(j), 4'(n + 1));
            end
            if (j == 0) check("cheio com um tabuleiro", 32'(cheio), 32'd0);
        end
        check("cheio", 32'(cheio), 32'd1);
        run_check("tabuleiro cheio j0 (8,8)", 1'b0, 3'd0, 4'd8, 4'd8, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/validador_pecas.md
Name: validador_pecas

Overview:
- Conflict validator and board store sitting directly downstream of the piece-placement FSM.
- Accepts a candidate piece (player, type, X/Y, direction), walks its cells one per clock and checks bounds and overlap against that player's 8x8 occupancy board. Returns `conflito`.
- On a later commit request, writes the validated piece into the board.
- Provides a registered read port so the game-execution and display stages can query board cells.

Parameters:
- `TAM_TAB`, 8, board side length; valid coordinates are 1..`TAM_TAB`, and 0 means "no switch".
- `MAX_PECAS`, 11, pieces per player (5 submarino + 2 cruzador + 2 hidroaviao + 1 encouracado + 1 porta-avioes).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears boards, counters, FSM.
- `valida`  in  1  check request; only its rising edge (sampled by `clk`) starts a check.
- `armazena`  in  1  commit request (pulse or level; rising edge sampled).
- `jogador`  in  1  board select, 0 or 1.
- `tipo`  in  3  0 submarino, 1 cruzador, 2 hidroaviao, 3 encouracado, 4 porta-avioes; 5..7 invalid.
- `X1`  in  4  anchor column, 1..8.
- `Y1`  in  4  anchor row, 1..8.
- `direcao`  in  1  0 horizontal, 1 vertical.
- `rd_jogador`  in  1  read-port board select.
- `rd_x`  in  4  read-port column.
- `rd_y`  in  4  read-port row.
- `conflito`  out  1  1 means the candidate is invalid.
- `pronto`  out  1  one-cycle pulse when `conflito` is updated.
- `gravado`  out  1  one-cycle pulse when a commit finishes.
- `qtd_pecas0`  out  4  pieces stored on board 0.
- `qtd_pecas1`  out  4  pieces stored on board 1.
- `cheio`  out  1  both counts equal `MAX_PECAS`.
- `rd_ocupado`  out  1  registered occupancy of (`rd_jogador`, `rd_x`, `rd_y`); 0 if the coordinate is out of range.

Behaviour:
- Reset values:
  - All outputs 0.
  - Both 64-bit boards cleared.
  - FSM in `OCIOSO`.
- Captured inputs: `jogador`, `tipo`, `X1`, `Y1`, `direcao` are latched on the capture edge. Later input changes do not affect a check or write in progress.
- Cell list (len cells, index k = 0..len-1):
  - Length by `tipo`: 0→1, 1→2, 3→4, 4→5.
  - Linear pieces: `direcao`=0 gives cells (X1+k, Y1); `direcao`=1 gives cells (X1, Y1+k).
  - Hidroaviao (len 3), `direcao`=0: (X1,Y1), (X1+1,Y1+1), (X1+2,Y1).
  - Hidroaviao (len 3), `direcao`=1: (X1,Y1), (X1+1,Y1+1), (X1,Y1+2).
- Arithmetic: all coordinate sums are 5-bit, with no wrap. A cell conflicts if x or y is 0, x or y exceeds `TAM_TAB`, or the cell is occupied on the captured board.
- FSM states:
  - `OCIOSO`: on `valida` rising edge, capture inputs, set k=0, go to `CHECA`.
  - `CHECA`:
    - Evaluates one cell per cycle and ORs the result into an internal flag.
    - Always runs all len cells (fixed latency); after k=len-1, go to `RESULTADO`.
    - An invalid `tipo` forces the flag to 1 and takes 1 cycle.
  - `RESULTADO`:
    - `conflito` ← flag; `pronto`=1 for this cycle.
    - If flag=1, go to `OCIOSO`; otherwise go to `AGUARDA`.
  - `AGUARDA`:
    - `armazena` rising edge: k=0, go to `GRAVA`.
    - Else `valida` rising edge: recapture, go to `CHECA`.
    - Both at once: `armazena` wins.
  - `GRAVA`:
    - Sets one cell per cycle.
    - After the last cell, increments the selected `qtd_pecas`, pulses `gravado`, goes to `OCIOSO`, and clears `conflito` to 0.
- Latency:
  - `pronto` is asserted len+1 cycles after the capture edge.
  - `gravado` is asserted len cycles after the commit edge.
- `conflito` holds its value until the next `RESULTADO` or commit.
- Ignored requests:
  - `armazena` outside `AGUARDA` is ignored (no write after a failed or absent check).
  - `valida` edges during `CHECA`/`GRAVA` are ignored.
  - A `valida` held high produces only one check.
- When a player's count is already `MAX_PECAS`, any check on that board returns `conflito`=1.
- Read port: `rd_ocupado` is updated every cycle with 1-cycle latency and reflects a write the cycle after that cell is set.
- `reset` mid-check or mid-write: immediate return to `OCIOSO` with empty boards. A partially written piece is not retained.

Optional Feature:
- Macro `VALIDADOR_ADJACENCIA_EN`.
- When defined, a cell also conflicts if any in-range 8-neighbour is occupied on the captured board (ships may not touch). Out-of-range neighbours are ignored.
- When undefined, only bounds and direct overlap count.
- Latency is identical in both builds.

Test Plan:
- After reset, cruzador j0 (3,4) `direcao`=0 → `pronto` 3 cycles after the edge with `conflito`=0. Then `armazena` → `gravado` after 2 cycles; `rd_ocupado`=1 at (3,4) and (4,4); `qtd_pecas0`=1.
- Porta-avioes j1 (5,2) `direcao`=0 → cell x=9 → `conflito`=1. A following `armazena` is ignored and `qtd_pecas1` stays 0.
- With the cruzador stored, submarino j0 (4,4) → `conflito`=1. Submarino j1 (4,4) → `conflito`=0 (boards independent).
- Hidroaviao j0 (1,7) `direcao`=1 → cell (1,9) → `conflito`=1. Same piece at (1,6) → `conflito`=0; commit sets (1,6), (2,7), (1,8).
- Adjacency: submarino j0 (5,5) next to stored (4,4). Undefined macro → `conflito`=0. `VALIDADOR_ADJACENCIA_EN` defined → `conflito`=1.
- Assert `reset` during the third `GRAVA` cycle of an encouracado → all `rd_ocupado`=0, counts 0. A new `valida` then works normally.
